imem_responder: RTL and testbench
=================================

Name: imem_responder

Overview:
- Instruction-memory responder that serves fetch-stage instruction reads.
- Accepts word-aligned PC requests over a valid/ready handshake and returns instructions after a fixed latency, in order.
- Supports multiple outstanding requests, response backpressure and a flush on PC redirect.
- Includes a load port for preloading program images from the bench or a boot loader.

Parameters:
- DWIDTH, 32, instruction/data word width.
- AWIDTH, 32, address width.
- BASE_ADDR, IMEM_BASE_ADDR (constants.svh), byte address of word 0.
- DEPTH_WORDS, 1024, memory depth in words; power of two.
- LATENCY, 2, cycles from request accept to earliest response valid; legal range 1..8.
- MAX_OUTST, 4, maximum requests in flight (delay line plus response queue); legal range LATENCY..16.

Ports:
- clk, in, 1, clock.
- rst_n, in, 1, synchronous active-low reset.
- req_valid_i, in, 1, fetch request valid.
- req_ready_o, out, 1, responder can accept a request.
- req_addr_i, in, AWIDTH, byte address of the requested instruction.
- flush_i, in, 1, redirect: discard all in-flight and queued responses.
- rsp_valid_o, out, 1, response valid.
- rsp_ready_i, in, 1, consumer accepts the response.
- rsp_addr_o, out, AWIDTH, address of the returned instruction.
- rsp_insn_o, out, DWIDTH, instruction word.
- rsp_err_o, out, 1, request was misaligned or out of range.
- load_we_i, in, 1, preload write enable.
- load_addr_i, in, AWIDTH, preload byte address.
- load_data_i, in, DWIDTH, preload data.

Behaviour:
- Clock and reset: clk is the only clock. Reset is synchronous, active-low on rst_n; all state clears on the rising edge of clk while rst_n=0.
- Reset values: req_ready_o=0, rsp_valid_o=0, rsp_addr_o=0, rsp_insn_o=0, rsp_err_o=0, outstanding count=0, delay line and queue empty. Memory contents are not reset.
- Ready: req_ready_o = rst_n & !flush_i & !load_we_i & (outstanding < MAX_OUTST). It is combinational from the registered count and inputs.
- Accept: a request is accepted when req_valid_i & req_ready_o. The memory is read in the accept cycle, and {addr, data, err} enter the LATENCY-stage delay line.
- Latency: a request accepted in cycle T presents rsp_valid_o=1 in cycle T+LATENCY, provided the response queue is empty. Otherwise it waits behind earlier responses. Ordering is strictly FIFO.
- Queue: the delay-line output enters a response queue of depth MAX_OUTST. rsp_* is driven from the queue head, and the head pops when rsp_valid_o & rsp_ready_i.
- Outstanding count: increments on accept and decrements on pop. A simultaneous accept and pop leaves it unchanged. Because accepts are gated by this count, the queue never overflows.
- Backpressure: while rsp_ready_i=0, rsp_valid_o, rsp_addr_o, rsp_insn_o and rsp_err_o hold stable.
- Error detection: err=1 when req_addr_i[1:0]!=0 or (req_addr_i-BASE_ADDR)>>2 >= DEPTH_WORDS. Subtraction is unsigned, so addresses below BASE_ADDR wrap and also flag. An errored response returns insn 32'h0000_0013 (NOP) and still completes in order.
- Word index: (addr-BASE_ADDR)[log2(DEPTH_WORDS)+1:2].
- Flush: when flush_i=1 in cycle T, the delay line and queue are emptied, the count goes to 0, and rsp_valid_o=0 in T+1. No request is accepted in T. A response handshake in cycle T is honoured; the consumer must ignore it.
- Preload write: when load_we_i=1, the word is written if load_addr_i is aligned and in range; otherwise the write is ignored. Requests are blocked in that cycle. A read in the following cycle returns the new data.
- Reset mid-operation: all in-flight requests are dropped and no response is emitted for them.

Optional Feature:
- Macro: IMEM_PERF_CNT_EN.
- When defined: adds outputs perf_req_o, perf_flush_drop_o and perf_stall_o, each 32 bits, reset to 0 and saturating at all-ones.
  - perf_req_o counts accepted requests.
  - perf_flush_drop_o counts entries discarded by flush (delay line plus queue occupancy at the flush).
  - perf_stall_o counts cycles with rsp_valid_o & !rsp_ready_i.
- When undefined: these ports and their counters do not exist, and behaviour is otherwise identical.

Test Plan:
- Basic read: preload word0=32'h0000_0093 and word1=32'h0010_0113 (default parameters). Request BASE_ADDR at T and BASE_ADDR+4 at T+1 with rsp_ready_i=1 → responses at T+2 and T+3 with matching addr, insn and err=0.
- Throughput limit: hold rsp_ready_i=0 and issue back-to-back requests → exactly 4 accepted, req_ready_o=0 thereafter, rsp_valid_o held on the first response. Release rsp_ready_i → 4 responses in order, one per cycle, and req_ready_o reasserts the cycle after the first pop.
- Errors: request BASE_ADDR+2 and BASE_ADDR+4096 → both responses have err=1 and insn=32'h0000_0013, and ordering with a valid request in between is preserved.
- Flush: issue 3 requests, then assert flush_i the cycle after the third accept → no response for any of them, count returns to 0. A new request of BASE_ADDR+8 afterwards returns after 2 cycles.
- Load/read hazard: load_we_i writing 32'hDEAD_BEEF at BASE_ADDR with req_valid_i high in the same cycle → request is not accepted. It is accepted next cycle and returns 32'hDEAD_BEEF.
- Reset: drop rst_n while 2 requests are in flight → all outputs 0 the next cycle and no stale response after rst_n rises. With IMEM_PERF_CNT_EN defined, all perf counters read 0.

Source files
------------

// File: rtl/imem_responder_if.sv
// Fetch-side bus of the instruction-memory responder: request, response, flush and preload port.
interface imem_responder_if #(
    parameter int AWIDTH = 32,
    parameter int DWIDTH = 32
);
    logic              req_valid_i;
    logic              req_ready_o;
    logic [AWIDTH-1:0] req_addr_i;
    logic              flush_i;
    logic              rsp_valid_o;
    logic              rsp_ready_i;
    logic [AWIDTH-1:0] rsp_addr_o;
    logic [DWIDTH-1:0] rsp_insn_o;
    logic              rsp_err_o;
    logic              load_we_i;
    logic [AWIDTH-1:0] load_addr_i;
    logic [DWIDTH-1:0] load_data_i;

    modport master (
        output req_valid_i, req_addr_i, flush_i, rsp_ready_i, load_we_i, load_addr_i, load_data_i,
        input  req_ready_o, rsp_valid_o, rsp_addr_o, rsp_insn_o, rsp_err_o
    );

    modport slave (
        input  req_valid_i, req_addr_i, flush_i, rsp_ready_i, load_we_i, load_addr_i, load_data_i,
        output req_ready_o, rsp_valid_o, rsp_addr_o, rsp_insn_o, rsp_err_o
    );
endinterface

// File: rtl/imem_responder.sv
// Fixed-latency, in-order instruction memory responder with flush and preload port.
// Optional IMEM_PERF_CNT_EN adds saturating request / flush-drop / stall counters.
module imem_responder #(
    parameter int                DWIDTH      = 32,
    parameter int                AWIDTH      = 32,
    parameter logic [AWIDTH-1:0] BASE_ADDR   = AWIDTH'(32'h8000_0000),
    parameter int                DEPTH_WORDS = 1024,
    parameter int                LATENCY     = 2,
    parameter int                MAX_OUTST   = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    imem_responder_if.slave   bus
`ifdef IMEM_PERF_CNT_EN
    ,
    output logic [31:0]       perf_req_o,
    output logic [31:0]       perf_flush_drop_o,
    output logic [31:0]       perf_stall_o
`endif
);
    localparam int IW   = $clog2(DEPTH_WORDS);
    // Stages between accept and queue push; with LATENCY==1 the accept feeds the queue directly.
    localparam int DL_N = (LATENCY > 1) ? LATENCY - 1 : 1;
    localparam int PW   = (MAX_OUTST > 1) ? $clog2(MAX_OUTST) : 1;
    localparam int CW   = $clog2(MAX_OUTST + 1);
    localparam logic [AWIDTH-1:0] DEPTH_A = AWIDTH'(DEPTH_WORDS);
    localparam logic [DWIDTH-1:0] NOP     = DWIDTH'(32'h0000_0013);

    typedef struct packed {
        logic [AWIDTH-1:0] addr;
        logic [DWIDTH-1:0] insn;
        logic              err;
    } rsp_t;

    // Returns {bad, word_index}; below-base addresses wrap and therefore flag as bad.
    function automatic logic [IW:0] addr_decode(input logic [AWIDTH-1:0] a);
        logic [AWIDTH-1:0] off;
        off = a - BASE_ADDR;
        return {(a[1:0] != 2'b00) || ((off >> 2) >= DEPTH_A), off[IW+1:2]};
    endfunction

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(MAX_OUTST - 1)) ? '0 : p + PW'(1);
    endfunction

    logic [DWIDTH-1:0] mem_q [DEPTH_WORDS];

    logic              dl_vld_q [DL_N];
    logic              dl_vld_d [DL_N];
    rsp_t              dl_ent_q [DL_N];
    rsp_t              dl_ent_d [DL_N];
    rsp_t              q_ent_q  [MAX_OUTST];
    rsp_t              q_ent_d  [MAX_OUTST];
    logic [PW-1:0]     q_wr_q, q_wr_d, q_rd_q, q_rd_d;
    logic [CW-1:0]     q_cnt_q, q_cnt_d, out_cnt_q, out_cnt_d;

    logic              req_ready_s, accept_s, pop_s, push_vld_s, load_ok_s;
    logic [IW:0]       req_dec_s, load_dec_s;
    rsp_t              acc_ent_s, push_ent_s;

    assign req_dec_s   = addr_decode(bus.req_addr_i);
    assign load_dec_s  = addr_decode(bus.load_addr_i);
    assign load_ok_s   = bus.load_we_i & ~load_dec_s[IW];
    assign req_ready_s = rst_n & ~bus.flush_i & ~bus.load_we_i & (out_cnt_q < CW'(MAX_OUTST));
    assign accept_s    = bus.req_valid_i & req_ready_s;
    assign pop_s       = (q_cnt_q != '0) & bus.rsp_ready_i;

    assign acc_ent_s.addr = bus.req_addr_i;
    assign acc_ent_s.insn = req_dec_s[IW] ? NOP : mem_q[req_dec_s[IW-1:0]];
    assign acc_ent_s.err  = req_dec_s[IW];

    assign bus.req_ready_o = req_ready_s;
    assign bus.rsp_valid_o = (q_cnt_q != '0);
    assign bus.rsp_addr_o  = q_ent_q[q_rd_q].addr;
    assign bus.rsp_insn_o  = q_ent_q[q_rd_q].insn;
    assign bus.rsp_err_o   = q_ent_q[q_rd_q].err;

    // Select what enters the response queue this cycle.
    always_comb begin
        push_vld_s = 1'b0;
        push_ent_s = '0;
        if (LATENCY == 1) begin
            push_vld_s = accept_s;
            push_ent_s = acc_ent_s;
        end else begin
            push_vld_s = dl_vld_q[DL_N-1];
            push_ent_s = dl_ent_q[DL_N-1];
        end
    end

    // Next state of the delay line, response queue and outstanding count.
    always_comb begin
        dl_vld_d  = dl_vld_q;
        dl_ent_d  = dl_ent_q;
        q_ent_d   = q_ent_q;
        q_wr_d    = q_wr_q;
        q_rd_d    = q_rd_q;
        q_cnt_d   = q_cnt_q;
        out_cnt_d = out_cnt_q;
        if (bus.flush_i) begin
            for (int i = 0; i < DL_N; i++) begin
                dl_vld_d[i] = 1'b0;
            end
            q_wr_d    = '0;
            q_rd_d    = '0;
            q_cnt_d   = '0;
            out_cnt_d = '0;
        end else begin
            if (LATENCY > 1) begin
                dl_vld_d[0] = accept_s;
                dl_ent_d[0] = acc_ent_s;
                for (int i = 1; i < DL_N; i++) begin
                    dl_vld_d[i] = dl_vld_q[i-1];
                    dl_ent_d[i] = dl_ent_q[i-1];
                end
            end else begin
                dl_vld_d[0] = 1'b0;
            end
            if (push_vld_s) begin
                q_ent_d[q_wr_q] = push_ent_s;
                q_wr_d          = ptr_inc(q_wr_q);
            end else begin
                q_wr_d = q_wr_q;
            end
            if (pop_s) begin
                q_rd_d = ptr_inc(q_rd_q);
            end else begin
                q_rd_d = q_rd_q;
            end
            q_cnt_d   = q_cnt_q + CW'(push_vld_s) - CW'(pop_s);
            out_cnt_d = out_cnt_q + CW'(accept_s) - CW'(pop_s);
        end
    end

    // State registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < DL_N; i++) begin
                dl_vld_q[i] <= 1'b0;
                dl_ent_q[i] <= '0;
            end
            for (int i = 0; i < MAX_OUTST; i++) begin
                q_ent_q[i] <= '0;
            end
            q_wr_q    <= '0;
            q_rd_q    <= '0;
            q_cnt_q   <= '0;
            out_cnt_q <= '0;
        end else begin
            dl_vld_q  <= dl_vld_d;
            dl_ent_q  <= dl_ent_d;
            q_ent_q   <= q_ent_d;
            q_wr_q    <= q_wr_d;
            q_rd_q    <= q_rd_d;
            q_cnt_q   <= q_cnt_d;
            out_cnt_q <= out_cnt_d;
        end
    end

    // Preload port; memory contents survive reset.
    always_ff @(posedge clk) begin
        if (load_ok_s) begin
            mem_q[load_dec_s[IW-1:0]] <= bus.load_data_i;
        end
    end

`ifdef IMEM_PERF_CNT_EN
    logic [31:0] perf_req_q, perf_req_d, perf_drop_q, perf_drop_d, perf_stall_q, perf_stall_d;
    logic [32:0] drop_sum_s;

    assign drop_sum_s        = {1'b0, perf_drop_q} + 33'(out_cnt_q);
    assign perf_req_o        = perf_req_q;
    assign perf_flush_drop_o = perf_drop_q;
    assign perf_stall_o      = perf_stall_q;

    // Saturating performance counters.
    always_comb begin
        perf_req_d   = perf_req_q;
        perf_drop_d  = perf_drop_q;
        perf_stall_d = perf_stall_q;
        if (accept_s && (perf_req_q != 32'hFFFF_FFFF)) begin
            perf_req_d = perf_req_q + 32'd1;
        end else begin
            perf_req_d = perf_req_q;
        end
        if (bus.flush_i) begin
            perf_drop_d = drop_sum_s[32] ? 32'hFFFF_FFFF : drop_sum_s[31:0];
        end else begin
            perf_drop_d = perf_drop_q;
        end
        if ((q_cnt_q != '0) && !bus.rsp_ready_i && (perf_stall_q != 32'hFFFF_FFFF)) begin
            perf_stall_d = perf_stall_q + 32'd1;
        end else begin
            perf_stall_d = perf_stall_q;
        end
    end

    // Counter registers.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            perf_req_q   <= 32'd0;
            perf_drop_q  <= 32'd0;
            perf_stall_q <= 32'd0;
        end else begin
            perf_req_q   <= perf_req_d;
            perf_drop_q  <= perf_drop_d;
            perf_stall_q <= perf_stall_d;
        end
    end
`endif
endmodule

// File: tb/tb_imem_responder.sv
// Scoreboard bench for imem_responder: directed stimulus pushes expectations, a monitor pops on handshakes.
module tb_imem_responder;
    localparam logic [31:0] BASE = 32'h8000_0000;
    localparam logic [31:0] NOP  = 32'h0000_0013;
    localparam logic [31:0] W0   = 32'h0000_0093;
    localparam logic [31:0] W1   = 32'h0010_0113;
    localparam logic [31:0] W2   = 32'h0020_0193;

    typedef struct {
        logic [31:0] addr;
        logic [31:0] insn;
        logic        err;
        int          cyc;
    } exp_t;

    logic clk;
    logic rst_n;
    int   cyc;
    int   checks;
    int   failures;
    exp_t sb[$];

    imem_responder_if #(.AWIDTH(32), .DWIDTH(32)) bus ();

`ifdef IMEM_PERF_CNT_EN
    logic [31:0] perf_req, perf_drop, perf_stall;
`endif

    imem_responder #(
        .DWIDTH(32), .AWIDTH(32), .BASE_ADDR(BASE),
        .DEPTH_WORDS(1024), .LATENCY(2), .MAX_OUTST(4)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
`ifdef IMEM_PERF_CNT_EN
        ,
        .perf_req_o        (perf_req),
        .perf_flush_drop_o (perf_drop),
        .perf_stall_o      (perf_stall)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Monitor: every response handshake outside flush/reset must match the scoreboard head.
    always @(negedge clk) begin
        if (rst_n && !bus.flush_i && bus.rsp_valid_o && bus.rsp_ready_i) begin
            if (sb.size() == 0) begin
                chk("unexpected_rsp", {32'd0, bus.rsp_addr_o}, 64'd0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk("rsp_addr", {32'd0, bus.rsp_addr_o}, {32'd0, e.addr});
                chk("rsp_insn", {32'd0, bus.rsp_insn_o}, {32'd0, e.insn});
                chk("rsp_err", {63'd0, bus.rsp_err_o}, {63'd0, e.err});
                if (e.cyc >= 0) chk("rsp_latency", 64'(cyc), 64'(e.cyc));
            end
        end
    end

    task automatic load(input logic [31:0] a, input logic [31:0] d);
        bus.load_we_i   = 1'b1;
        bus.load_addr_i = a;
        bus.load_data_i = d;
        step();
        bus.load_we_i   = 1'b0;
    endtask

    // Hold a request until accepted (bounded); push the hand-computed expectation on accept.
    task automatic req_issue(input logic [31:0] a, input logic [31:0] insn, input logic err, input int lat);
        bit done;
        done = 1'b0;
        bus.req_valid_i = 1'b1;
        bus.req_addr_i  = a;
        for (int i = 0; i < 20 && !done; i++) begin
            @(negedge clk);
            if (bus.req_ready_o) begin
                sb.push_back('{addr: a, insn: insn, err: err, cyc: (lat < 0) ? -1 : cyc + lat});
                done = 1'b1;
            end
            step();
        end
        if (!done) chk("req_accept_timeout", 64'd0, 64'd1);
        bus.req_valid_i = 1'b0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    initial begin
        checks = 0; failures = 0; cyc = 0;
        rst_n = 1'b0;
        bus.req_valid_i = 1'b0; bus.req_addr_i = 32'd0; bus.flush_i = 1'b0;
        bus.rsp_ready_i = 1'b1; bus.load_we_i = 1'b0; bus.load_addr_i = 32'd0; bus.load_data_i = 32'd0;
        idle(3);
        @(negedge clk);
        chk("rst_req_ready", {63'd0, bus.req_ready_o}, 64'd0);
        chk("rst_rsp_valid", {63'd0, bus.rsp_valid_o}, 64'd0);
        chk("rst_rsp_addr", {32'd0, bus.rsp_addr_o}, 64'd0);
        chk("rst_rsp_insn", {32'd0, bus.rsp_insn_o}, 64'd0);
        chk("rst_rsp_err", {63'd0, bus.rsp_err_o}, 64'd0);
        step();
        rst_n = 1'b1;
        @(negedge clk);
        chk("ready_after_rst", {63'd0, bus.req_ready_o}, 64'd1);
        step();

        load(BASE, W0);
        load(BASE + 32'd4, W1);
        load(BASE + 32'd8, W2);
        load(BASE + 32'd2, 32'h1234_5678);

        // Basic back-to-back reads.
        req_issue(BASE, W0, 1'b0, 2);
        req_issue(BASE + 32'd4, W1, 1'b0, 2);
        idle(4);

        // Errors interleaved with a valid request; misaligned load above was ignored.
        req_issue(BASE + 32'd2, NOP, 1'b1, 2);
        req_issue(BASE + 32'd4, W1, 1'b0, 2);
        req_issue(BASE + 32'd4096, NOP, 1'b1, 2);
        req_issue(BASE - 32'd4, NOP, 1'b1, 2);
        idle(4);

        // Throughput limit under backpressure.
        bus.rsp_ready_i = 1'b0;
        for (int i = 0; i < 6; i++) begin
            logic [31:0] a;
            a = (i % 2 == 1) ? BASE + 32'd4 : BASE;
            bus.req_valid_i = 1'b1;
            bus.req_addr_i  = a;
            @(negedge clk);
            chk("tput_req_ready", {63'd0, bus.req_ready_o}, (i < 4) ? 64'd1 : 64'd0);
            if (bus.req_ready_o) sb.push_back('{addr: a, insn: (i % 2 == 1) ? W1 : W0, err: 1'b0, cyc: -1});
            if (i >= 4) begin
                chk("tput_hold_valid", {63'd0, bus.rsp_valid_o}, 64'd1);
                chk("tput_hold_addr", {32'd0, bus.rsp_addr_o}, {32'd0, BASE});
            end
            step();
        end
        bus.req_valid_i = 1'b0;
        bus.rsp_ready_i = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("drain_valid", {63'd0, bus.rsp_valid_o}, (i < 4) ? 64'd1 : 64'd0);
            if (i < 2) chk("drain_req_ready", {63'd0, bus.req_ready_o}, 64'(i));
            step();
        end

        // Flush with three requests in flight.
        bus.rsp_ready_i = 1'b0;
        req_issue(BASE, W0, 1'b0, -1);
        req_issue(BASE + 32'd4, W1, 1'b0, -1);
        req_issue(BASE + 32'd8, W2, 1'b0, -1);
        bus.flush_i = 1'b1;
        sb.delete();
        @(negedge clk);
        chk("flush_blocks_req", {63'd0, bus.req_ready_o}, 64'd0);
        step();
        bus.flush_i = 1'b0;
        bus.rsp_ready_i = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("flush_no_rsp", {63'd0, bus.rsp_valid_o}, 64'd0);
            chk("flush_req_ready", {63'd0, bus.req_ready_o}, 64'd1);
            step();
        end
        req_issue(BASE + 32'd8, W2, 1'b0, 2);
        idle(4);

        // Load/read hazard.
        bus.load_we_i = 1'b1; bus.load_addr_i = BASE; bus.load_data_i = 32'hDEAD_BEEF;
        bus.req_valid_i = 1'b1; bus.req_addr_i = BASE;
        @(negedge clk);
        chk("load_blocks_req", {63'd0, bus.req_ready_o}, 64'd0);
        step();
        bus.load_we_i = 1'b0;
        req_issue(BASE, 32'hDEAD_BEEF, 1'b0, 2);
        idle(4);

        // Reset with two requests in flight.
        bus.rsp_ready_i = 1'b0;
        req_issue(BASE, 32'hDEAD_BEEF, 1'b0, -1);
        req_issue(BASE + 32'd4, W1, 1'b0, -1);
        rst_n = 1'b0;
        sb.delete();
        step();
        @(negedge clk);
        chk("mid_rst_rsp_valid", {63'd0, bus.rsp_valid_o}, 64'd0);
        chk("mid_rst_rsp_addr", {32'd0, bus.rsp_addr_o}, 64'd0);
        chk("mid_rst_rsp_insn", {32'd0, bus.rsp_insn_o}, 64'd0);
        chk("mid_rst_rsp_err", {63'd0, bus.rsp_err_o}, 64'd0);
        chk("mid_rst_req_ready", {63'd0, bus.req_ready_o}, 64'd0);
`ifdef IMEM_PERF_CNT_EN
        chk("perf_req_rst", {32'd0, perf_req}, 64'd0);
        chk("perf_drop_rst", {32'd0, perf_drop}, 64'd0);
        chk("perf_stall_rst", {32'd0, perf_stall}, 64'd0);
`endif
        step();
        rst_n = 1'b1;
        bus.rsp_ready_i = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("post_rst_no_rsp", {63'd0, bus.rsp_valid_o}, 64'd0);
            step();
        end

        idle(2);
        chk("scoreboard_empty", 64'(sb.size()), 64'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout actual=running required=finished");
        $fatal(1, "timeout");
    end
endmodule
